branch_redirect_ctrl: RTL and testbench

Fetch-side branch predictor and EX-stage redirect/flush sequencer for the RV32I pipeline. It holds a direct-mapped BTB with 2-bit saturating counters and supplies a predicted next PC to IF. It consumes the EX-stage jump resolution (jump flag plus computed target) and detects mispredicts. On a mispredict it flushes IF/ID and redirects the PC, holding the redirect across fetch stalls.

---
 rtl/branch_redirect_ctrl.sv | 92 +++++++++
 tb/tb_branch_redirect_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl: direct-mapped BTB predictor for IF plus EX-stage
// mispredict redirect/flush sequencer that holds the redirect across fetch stalls.
module branch_redirect_ctrl #(
  parameter int         INDEX_W  = 4,
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] IfPc,
  output logic        PredTaken,
  output logic [31:0] PredTarget,
  input  logic        ExValid,
  input  logic        ExIsBranch,
  input  logic        ExIsJump,
  input  logic [31:0] ExPc,
  input  logic        ExJumpFlag,
  input  logic [31:0] ExTarget,
  input  logic        ExPredTaken,
  input  logic [31:0] ExPredTarget,
  input  logic        FetchStall,
  output logic        RedirectValid,
  output logic [31:0] RedirectPc,
  output logic        FlushIF,
  output logic        FlushID,
  output logic [31:0] BranchCnt,
  output logic [31:0] MispredictCnt
);
  localparam int N  = 1 << INDEX_W;
  localparam int TW = 32 - INDEX_W - 2;
  typedef enum logic {IDLE, PENDING} state_t;
  state_t              r_state;
  logic [31:0]         r_pc;
  logic                r_valid [N];
  logic [TW-1:0]       r_tag   [N];
  logic [31:0]         r_tgt   [N];
  logic [1:0]          r_cnt   [N];
  logic [INDEX_W-1:0]  w_if_idx, w_ex_idx;
  logic                w_if_hit, w_ex_hit, w_r, w_m;
  logic [31:0]         w_corr;
  assign w_if_idx = IfPc[INDEX_W+1:2];
  assign w_ex_idx = ExPc[INDEX_W+1:2];
  assign w_if_hit = r_valid[w_if_idx] && r_tag[w_if_idx] == IfPc[31:INDEX_W+2];
  assign w_ex_hit = r_valid[w_ex_idx] && r_tag[w_ex_idx] == ExPc[31:INDEX_W+2];
  assign PredTaken  = w_if_hit && r_cnt[w_if_idx][1];
  assign PredTarget = w_if_hit ? r_tgt[w_if_idx] : IfPc + 32'd4;
  assign w_r    = ExValid && (ExIsBranch || ExIsJump) && r_state == IDLE;
  assign w_m    = w_r && (ExJumpFlag ? (!ExPredTaken || ExPredTarget != ExTarget) : ExPredTaken);
  assign w_corr = ExJumpFlag ? ExTarget : ExPc + 32'd4;
  always_comb begin
    RedirectValid = w_m || r_state == PENDING;
    RedirectPc    = r_state == PENDING ? r_pc : (w_m ? w_corr : 32'd0);
    FlushIF       = w_m || (r_state == PENDING && FetchStall);
    FlushID       = FlushIF;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_pc          <= 32'd0;
      BranchCnt     <= 32'd0;
      MispredictCnt <= 32'd0;
    end else begin
      if (w_r) BranchCnt <= BranchCnt + 32'd1;
      if (w_m) MispredictCnt <= MispredictCnt + 32'd1;
      if (r_state == IDLE && w_m && FetchStall) begin
        r_state <= PENDING;
        r_pc    <= w_corr;
      end else if (r_state == PENDING && !FetchStall) begin
        r_state <= IDLE;
      end
    end
  end
  // Lookup reads the array combinationally, so this edge-time write is naturally read-before-write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        r_valid[i] <= 1'b0;
        r_cnt[i]   <= CNT_INIT;
      end
    end else if (w_r) begin
      if (w_ex_hit) begin
        if (ExJumpFlag) r_tgt[w_ex_idx] <= ExTarget;
        r_cnt[w_ex_idx] <= ExJumpFlag ? (r_cnt[w_ex_idx] == 2'd3 ? 2'd3 : r_cnt[w_ex_idx] + 2'd1)
                                      : (r_cnt[w_ex_idx] == 2'd0 ? 2'd0 : r_cnt[w_ex_idx] - 2'd1);
      end else if (ExJumpFlag) begin
        r_valid[w_ex_idx] <= 1'b1;
        r_tag[w_ex_idx]   <= ExPc[31:INDEX_W+2];
        r_tgt[w_ex_idx]   <= ExTarget;
        r_cnt[w_ex_idx]   <= ExIsJump ? 2'b11 : 2'b10;
      end
    end
  end
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb_branch_redirect_ctrl: directed-vector bench for branch_redirect_ctrl
// with hand-computed expectations checked by immediate assertions.
module tb_branch_redirect_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] IfPc;
  logic        PredTaken;
  logic [31:0] PredTarget;
  logic        ExValid, ExIsBranch, ExIsJump, ExJumpFlag, ExPredTaken, FetchStall;
  logic [31:0] ExPc, ExTarget, ExPredTarget;
  logic        RedirectValid, FlushIF, FlushID;
  logic [31:0] RedirectPc, BranchCnt, MispredictCnt;
  int          n_vec = 0;
  int          n_err = 0;
  branch_redirect_ctrl dut (
    .clk(clk), .rst(rst), .IfPc(IfPc), .PredTaken(PredTaken), .PredTarget(PredTarget),
    .ExValid(ExValid), .ExIsBranch(ExIsBranch), .ExIsJump(ExIsJump), .ExPc(ExPc),
    .ExJumpFlag(ExJumpFlag), .ExTarget(ExTarget), .ExPredTaken(ExPredTaken),
    .ExPredTarget(ExPredTarget), .FetchStall(FetchStall), .RedirectValid(RedirectValid),
    .RedirectPc(RedirectPc), .FlushIF(FlushIF), .FlushID(FlushID),
    .BranchCnt(BranchCnt), .MispredictCnt(MispredictCnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic ex(input logic v, input logic br, input logic jp, input logic [31:0] pc,
                    input logic fl, input logic [31:0] tg, input logic pt, input logic [31:0] ptg);
    ExValid = v; ExIsBranch = br; ExIsJump = jp; ExPc = pc;
    ExJumpFlag = fl; ExTarget = tg; ExPredTaken = pt; ExPredTarget = ptg;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic redir(input string tag, input logic v, input logic [31:0] pc, input logic f);
    #1;
    chk({tag, "_rv"}, {31'd0, RedirectValid}, {31'd0, v});
    chk({tag, "_rpc"}, RedirectPc, pc);
    chk({tag, "_fif"}, {31'd0, FlushIF}, {31'd0, f});
    chk({tag, "_fid"}, {31'd0, FlushID}, {31'd0, f});
  endtask
  task automatic look(input string tag, input logic [31:0] pc, input logic t, input logic [31:0] tg);
    IfPc = pc;
    #1;
    chk({tag, "_pt"}, {31'd0, PredTaken}, {31'd0, t});
    chk({tag, "_ptg"}, PredTarget, tg);
  endtask
  task automatic cnts(input string tag, input logic [31:0] b, input logic [31:0] m);
    chk({tag, "_bcnt"}, BranchCnt, b);
    chk({tag, "_mcnt"}, MispredictCnt, m);
  endtask
  initial begin
    rst = 1'b1; IfPc = 32'h100; FetchStall = 1'b0;
    ex(0, 0, 0, 0, 0, 0, 0, 0);
    tick; tick;
    rst = 1'b0;
    redir("reset", 0, 32'h0, 0);
    cnts("reset", 0, 0);
    look("cold", 32'h100, 0, 32'h104);
    // taken BEQ predicted not-taken: immediate redirect, lookup still sees old (empty) entry
    ex(1, 1, 0, 32'h100, 1, 32'h80, 0, 32'h0);
    redir("beq_taken", 1, 32'h80, 1);
    look("beq_rbw", 32'h100, 0, 32'h104);
    tick;
    ex(0, 0, 0, 0, 0, 0, 0, 0);
    look("beq_alloc", 32'h100, 1, 32'h80);
    cnts("beq_alloc", 1, 1);
    redir("beq_after", 0, 32'h0, 0);
    ex(1, 1, 0, 32'h100, 0, 32'h80, 1, 32'h80);
    redir("nt1", 1, 32'h104, 1);
    tick;
    ex(0, 0, 0, 0, 0, 0, 0, 0);
    look("nt1_cnt1", 32'h100, 0, 32'h80);
    cnts("nt1", 2, 2);
    ex(1, 1, 0, 32'h100, 0, 32'h80, 0, 32'h104);
    redir("nt2", 0, 32'h0, 0);
    tick;
    ex(0, 0, 0, 0, 0, 0, 0, 0);
    look("nt2_cnt0", 32'h100, 0, 32'h80);
    cnts("nt2", 3, 2);
    // mispredict under a 3-cycle fetch stall, wrong-path branches arrive meanwhile
    FetchStall = 1'b1;
    ex(1, 1, 0, 32'h140, 1, 32'h180, 0, 32'h0);
    redir("stall_c0", 1, 32'h180, 1);
    tick;
    ex(1, 1, 0, 32'h500, 1, 32'h600, 0, 32'h0);
    redir("stall_c1", 1, 32'h180, 1);
    tick;
    redir("stall_c2", 1, 32'h180, 1);
    tick;
    FetchStall = 1'b0;
    redir("stall_c3", 1, 32'h180, 0);
    tick;
    ex(0, 0, 0, 0, 0, 0, 0, 0);
    redir("stall_done", 0, 32'h0, 0);
    cnts("stall", 4, 3);
    look("wrongpath_none", 32'h500, 0, 32'h504);
    look("stall_alloc", 32'h140, 1, 32'h180);
    // JALR with wrong predicted target (0x200 shares index 0 with 0x140)
    ex(1, 0, 1, 32'h200, 1, 32'h340, 1, 32'h300);
    redir("jalr", 1, 32'h340, 1);
    tick;
    ex(0, 0, 0, 0, 0, 0, 0, 0);
    look("jalr_tgt", 32'h200, 1, 32'h340);
    look("jalr_evict", 32'h140, 0, 32'h144);
    cnts("jalr", 5, 4);
    // aliasing 0x1000 / 0x2000 on index 0
    ex(1, 1, 0, 32'h1000, 1, 32'h1800, 0, 32'h0);
    tick;
    ex(1, 1, 0, 32'h2000, 1, 32'h2800, 0, 32'h0);
    look("alias_rbw", 32'h1000, 1, 32'h1800);
    tick;
    ex(0, 0, 0, 0, 0, 0, 0, 0);
    look("alias_miss", 32'h1000, 0, 32'h1004);
    look("alias_new", 32'h2000, 1, 32'h2800);
    cnts("alias", 7, 6);
    // not-taken mispredict at top of address space: fall-through wraps to 0
    ex(1, 1, 0, 32'hFFFF_FFFC, 0, 32'h0, 1, 32'h10);
    #1;
    chk("wrap_rv", {31'd0, RedirectValid}, 32'd1);
    chk("wrap_rpc", RedirectPc, 32'h0);
    tick;
    // reset while PENDING
    FetchStall = 1'b1;
    ex(1, 1, 0, 32'h300, 1, 32'h40, 0, 32'h0);
    tick;
    ex(0, 0, 0, 0, 0, 0, 0, 0);
    redir("pend", 1, 32'h40, 1);
    cnts("pend", 9, 8);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    redir("rst_pend", 0, 32'h0, 0);
    cnts("rst_pend", 0, 0);
    look("rst_miss", 32'h2000, 0, 32'h2004);
    look("rst_miss2", 32'h300, 0, 32'h304);
    tick;
    redir("rst_idle", 0, 32'h0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
